fifo_ram_controller: RTL and testbench

- FSM-based sequencer for the 32x8 single-port FIFO RAM.
- Owns write/read pointers, occupancy count and full/empty flags.
- Drives the RAM control pins (address, wr_rd, OutEnable, ChipEnable, Clear) and captures RAM read data into a registered output.
- Sits between the producer/consumer logic and the RAM; arbitrates simultaneous push/pop onto the single port.

---
 rtl/fifo_ram_controller_if.sv | 45 ++++
 rtl/fifo_ram_controller.sv | 184 ++++++++++++++++++
 tb/tb_fifo_ram_controller.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/fifo_ram_controller_if.sv
// Producer/consumer handshake bundle for fifo_ram_controller.
// Watermark flags exist only when FIFO_CTRL_WATERMARK_EN is defined.
interface fifo_ram_controller_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5
);
    logic              push;
    logic              pop;
    logic              flush;
    logic [DATA_W-1:0] data_in;
    logic              ready;
    logic [DATA_W-1:0] data_out;
    logic              data_valid;
    logic              full;
    logic              empty;
    logic [ADDR_W:0]   count;
    logic              overflow;
    logic              underflow;
`ifdef FIFO_CTRL_WATERMARK_EN
    logic              almost_full;
    logic              almost_empty;

    modport master (
        output push, pop, flush, data_in,
        input  ready, data_out, data_valid, full, empty, count,
        input  overflow, underflow, almost_full, almost_empty
    );
    modport slave (
        input  push, pop, flush, data_in,
        output ready, data_out, data_valid, full, empty, count,
        output overflow, underflow, almost_full, almost_empty
    );
`else
    modport master (
        output push, pop, flush, data_in,
        input  ready, data_out, data_valid, full, empty, count,
        input  overflow, underflow
    );
    modport slave (
        input  push, pop, flush, data_in,
        output ready, data_out, data_valid, full, empty, count,
        output overflow, underflow
    );
`endif
endinterface

// File: rtl/fifo_ram_controller.sv
// FSM sequencer for a 32x8 single-port FIFO RAM: pointers, occupancy, flags, RAM pin decode.
// Optional watermark flags are enabled with the FIFO_CTRL_WATERMARK_EN macro.
//
// state | meaning
// CLR   | RAM zeroed on closing edge, pointers and count cleared
// IDLE  | ready=1, arbitrate push/pop/flush
// WR    | single write at wr_ptr
// RD    | single read at rd_ptr, data_out captured on closing edge
// WR_RD | write phase then read phase (push+pop, not full)
// RD_WR | read phase then write phase (push+pop while full)
module fifo_ram_controller #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5
`ifdef FIFO_CTRL_WATERMARK_EN
    ,
    parameter int AF_LEVEL = 28,
    parameter int AE_LEVEL = 4
`endif
) (
    input  logic                  clk,
    input  logic                  Clear,
    fifo_ram_controller_if.slave  bus,
    output logic [ADDR_W-1:0]     ram_address,
    output logic [DATA_W-1:0]     ram_data_in,
    output logic                  ram_wr_rd,
    output logic                  ram_OutEnable,
    output logic                  ram_ChipEnable,
    output logic                  ram_Clear,
    input  logic [DATA_W-1:0]     ram_data_out
);
    localparam int              DEPTH      = 1 << ADDR_W;
    localparam logic [ADDR_W:0] COUNT_FULL = (ADDR_W+1)'(DEPTH);

    typedef enum logic [2:0] {CLR, IDLE, WR, RD, WR_RD, RD_WR} state_t;

    state_t            state;
    logic              phase;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [DATA_W-1:0] wdata;
    logic [ADDR_W:0]   count;
    logic [ADDR_W:0]   count_nxt;
    logic              ready;
    logic [DATA_W-1:0] data_out;
    logic              data_valid;
    logic              full;
    logic              empty;
    logic              overflow;
    logic              underflow;
    logic              wr_phase;
    logic              rd_phase;

    assign wr_phase = (state == WR) || (state == WR_RD && !phase) || (state == RD_WR && phase);
    assign rd_phase = (state == RD) || (state == RD_WR && !phase) || (state == WR_RD && phase);

    always_comb begin
        count_nxt = count;
        if (state == CLR)
            count_nxt = '0;
        else if (wr_phase)
            count_nxt = count + 1'b1;
        else if (rd_phase)
            count_nxt = count - 1'b1;
    end

    assign ram_ChipEnable = (state != IDLE);
    assign ram_Clear      = (state != CLR);
    assign ram_wr_rd      = wr_phase;
    assign ram_OutEnable  = rd_phase;
    assign ram_address    = wr_phase ? wr_ptr : rd_ptr;
    assign ram_data_in    = wdata;

    always_ff @(posedge clk or negedge Clear) begin
        if (!Clear) begin
            state      <= CLR;
            phase      <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            wdata      <= '0;
            count      <= '0;
            ready      <= 1'b0;
            data_out   <= '0;
            data_valid <= 1'b0;
            full       <= 1'b0;
            empty      <= 1'b1;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
            count      <= count_nxt;
            full       <= (count_nxt == COUNT_FULL);
            empty      <= (count_nxt == '0);

            if (wr_phase)
                wr_ptr <= wr_ptr + 1'b1;
            if (rd_phase) begin
                rd_ptr     <= rd_ptr + 1'b1;
                data_out   <= ram_data_out;
                data_valid <= 1'b1;
            end

            case (state)
                CLR: begin
                    wr_ptr <= '0;
                    rd_ptr <= '0;
                    state  <= IDLE;
                    ready  <= 1'b1;
                end
                IDLE: begin
                    phase <= 1'b0;
                    if (bus.flush) begin
                        state <= CLR;
                        ready <= 1'b0;
                    end else if (bus.push && bus.pop) begin
                        // full and empty are exclusive; empty falls into WR_RD so the read sees the new word
                        wdata <= bus.data_in;
                        state <= full ? RD_WR : WR_RD;
                        ready <= 1'b0;
                    end else if (bus.push && !full) begin
                        wdata <= bus.data_in;
                        state <= WR;
                        ready <= 1'b0;
                    end else if (bus.pop && !empty) begin
                        wdata <= bus.data_in;
                        state <= RD;
                        ready <= 1'b0;
                    end else if (bus.push) begin
                        overflow <= 1'b1;
                    end else if (bus.pop) begin
                        underflow <= 1'b1;
                    end
                end
                WR, RD: begin
                    state <= IDLE;
                    ready <= 1'b1;
                end
                WR_RD, RD_WR: begin
                    if (!phase) begin
                        phase <= 1'b1;
                    end else begin
                        phase <= 1'b0;
                        state <= IDLE;
                        ready <= 1'b1;
                    end
                end
                default: begin
                    state <= CLR;
                    ready <= 1'b0;
                end
            endcase
        end
    end

`ifdef FIFO_CTRL_WATERMARK_EN
    localparam logic [ADDR_W:0] AF_C = (ADDR_W+1)'(AF_LEVEL);
    localparam logic [ADDR_W:0] AE_C = (ADDR_W+1)'(AE_LEVEL);
    logic almost_full;
    logic almost_empty;

    always_ff @(posedge clk or negedge Clear) begin
        if (!Clear) begin
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
        end else begin
            almost_full  <= (count_nxt >= AF_C);
            almost_empty <= (count_nxt <= AE_C);
        end
    end

    assign bus.almost_full  = almost_full;
    assign bus.almost_empty = almost_empty;
`endif

    assign bus.ready      = ready;
    assign bus.data_out   = data_out;
    assign bus.data_valid = data_valid;
    assign bus.full       = full;
    assign bus.empty      = empty;
    assign bus.count      = count;
    assign bus.overflow   = overflow;
    assign bus.underflow  = underflow;
endmodule

// File: tb/tb_fifo_ram_controller.sv
// Directed bench for fifo_ram_controller with a behavioural 32x8 single-port RAM.
module tb_fifo_ram_controller;
    logic       clk = 1'b0;
    logic       Clear;
    logic [4:0] ram_address;
    logic [7:0] ram_data_in;
    logic       ram_wr_rd;
    logic       ram_OutEnable;
    logic       ram_ChipEnable;
    logic       ram_Clear;
    logic [7:0] ram_data_out;
    logic [7:0] mem [32];

    int n_cmp = 0;
    int n_err = 0;

    fifo_ram_controller_if #(.DATA_W(8), .ADDR_W(5)) bus ();

    fifo_ram_controller #(.DATA_W(8), .ADDR_W(5)) dut (
        .clk            (clk),
        .Clear          (Clear),
        .bus            (bus),
        .ram_address    (ram_address),
        .ram_data_in    (ram_data_in),
        .ram_wr_rd      (ram_wr_rd),
        .ram_OutEnable  (ram_OutEnable),
        .ram_ChipEnable (ram_ChipEnable),
        .ram_Clear      (ram_Clear),
        .ram_data_out   (ram_data_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_ChipEnable) begin
            if (!ram_Clear) begin
                for (int i = 0; i < 32; i++) mem[i] <= 8'h00;
            end else if (ram_wr_rd) begin
                mem[ram_address] <= ram_data_in;
            end
        end
    end
    assign ram_data_out = (ram_ChipEnable && ram_OutEnable && !ram_wr_rd) ? mem[ram_address] : 8'h00;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_ready;
        int n = 0;
        while (!bus.ready && n < 20) begin
            tick;
            n++;
        end
        if (!bus.ready) check("ready_timeout", 32'(bus.ready), 32'd1);
    endtask

    task automatic op(input logic p, input logic q, input logic f, input logic [7:0] d);
        wait_ready;
        bus.push    = p;
        bus.pop     = q;
        bus.flush   = f;
        bus.data_in = d;
        tick;
        bus.push  = 1'b0;
        bus.pop   = 1'b0;
        bus.flush = 1'b0;
    endtask

    initial begin
        Clear       = 1'b0;
        bus.push    = 1'b0;
        bus.pop     = 1'b0;
        bus.flush   = 1'b0;
        bus.data_in = 8'h00;
        repeat (3) @(negedge clk);

        check("rst_ready", 32'(bus.ready), 32'd0);
        check("rst_empty", 32'(bus.empty), 32'd1);
        check("rst_full", 32'(bus.full), 32'd0);
        check("rst_count", 32'(bus.count), 32'd0);
        check("rst_dvalid", 32'(bus.data_valid), 32'd0);
        check("rst_dout", 32'(bus.data_out), 32'd0);

        Clear = 1'b1;
        #1;
        check("clr_ce", 32'(ram_ChipEnable), 32'd1);
        check("clr_rclear", 32'(ram_Clear), 32'd0);
        @(negedge clk);
        check("idle_ready", 32'(bus.ready), 32'd1);
        check("idle_rclear", 32'(ram_Clear), 32'd1);
        check("idle_ce", 32'(ram_ChipEnable), 32'd0);

        // single push / pop
        op(1, 0, 0, 8'hA5);
        check("wr_wrrd", 32'(ram_wr_rd), 32'd1);
        check("wr_addr", 32'(ram_address), 32'd0);
        check("wr_din", 32'(ram_data_in), 32'hA5);
        check("wr_ready", 32'(bus.ready), 32'd0);
        tick;
        check("push1_count", 32'(bus.count), 32'd1);
        check("push1_empty", 32'(bus.empty), 32'd0);
        op(0, 1, 0, 8'h00);
        check("rd_oe", 32'(ram_OutEnable), 32'd1);
        check("rd_dvalid_early", 32'(bus.data_valid), 32'd0);
        tick;
        check("rd_dvalid", 32'(bus.data_valid), 32'd1);
        check("rd_dout", 32'(bus.data_out), 32'hA5);
        check("rd_empty", 32'(bus.empty), 32'd1);
        tick;
        check("rd_dvalid_pulse", 32'(bus.data_valid), 32'd0);

        // fill, overflow, drain in order
        for (int i = 0; i < 32; i++) begin
            op(1, 0, 0, 8'(i));
            tick;
        end
        check("fill_full", 32'(bus.full), 32'd1);
        check("fill_count", 32'(bus.count), 32'd32);
        op(1, 0, 0, 8'hEE);
        check("ovf_pulse", 32'(bus.overflow), 32'd1);
        check("ovf_count", 32'(bus.count), 32'd32);
        check("ovf_ready", 32'(bus.ready), 32'd1);
        tick;
        check("ovf_clear", 32'(bus.overflow), 32'd0);
        for (int i = 0; i < 32; i++) begin
            op(0, 1, 0, 8'h00);
            tick;
            check("drain_data", 32'(bus.data_out), 32'(i));
        end
        check("drain_empty", 32'(bus.empty), 32'd1);
        check("drain_full", 32'(bus.full), 32'd0);

        // push+pop on empty goes write-then-read
        op(1, 1, 0, 8'h3C);
        check("wrrd_ph0_wr", 32'(ram_wr_rd), 32'd1);
        tick;
        check("wrrd_ph1_oe", 32'(ram_OutEnable), 32'd1);
        tick;
        check("wrrd_dvalid", 32'(bus.data_valid), 32'd1);
        check("wrrd_dout", 32'(bus.data_out), 32'h3C);
        check("wrrd_count", 32'(bus.count), 32'd0);
        check("wrrd_no_udf", 32'(bus.underflow), 32'd0);
        op(0, 1, 0, 8'h00);
        check("udf_pulse", 32'(bus.underflow), 32'd1);
        check("udf_dvalid", 32'(bus.data_valid), 32'd0);
        tick;
        check("udf_clear", 32'(bus.underflow), 32'd0);

        // push+pop while full goes read-then-write
        for (int i = 0; i < 32; i++) begin
            op(1, 0, 0, 8'(8'h40 + i));
            tick;
        end
        op(1, 1, 0, 8'h77);
        check("rdwr_ph0_oe", 32'(ram_OutEnable), 32'd1);
        tick;
        check("rdwr_ph1_wr", 32'(ram_wr_rd), 32'd1);
        check("rdwr_dout", 32'(bus.data_out), 32'h40);
        tick;
        check("rdwr_count", 32'(bus.count), 32'd32);
        check("rdwr_full", 32'(bus.full), 32'd1);
        for (int i = 1; i < 32; i++) begin
            op(0, 1, 0, 8'h00);
            tick;
            check("rdwr_drain", 32'(bus.data_out), 32'(8'h40 + i));
        end
        op(0, 1, 0, 8'h00);
        tick;
        check("rdwr_last", 32'(bus.data_out), 32'h77);
        check("rdwr_empty", 32'(bus.empty), 32'd1);

        // flush
        for (int i = 0; i < 5; i++) begin
            op(1, 0, 0, 8'(8'h90 + i));
            tick;
        end
        check("pre_flush_count", 32'(bus.count), 32'd5);
        op(0, 0, 1, 8'h00);
        check("flush_rclear", 32'(ram_Clear), 32'd0);
        check("flush_ready", 32'(bus.ready), 32'd0);
        tick;
        check("flush_count", 32'(bus.count), 32'd0);
        check("flush_empty", 32'(bus.empty), 32'd1);
        check("flush_ready_back", 32'(bus.ready), 32'd1);

        // asynchronous Clear during a write
        op(1, 0, 0, 8'h11);
        tick;
        op(1, 0, 0, 8'h99);
        check("midwr_count", 32'(bus.count), 32'd1);
        #2;
        Clear = 1'b0;
        #1;
        check("async_count", 32'(bus.count), 32'd0);
        check("async_empty", 32'(bus.empty), 32'd1);
        check("async_ready", 32'(bus.ready), 32'd0);
        check("async_rclear", 32'(ram_Clear), 32'd0);
        @(negedge clk);
        Clear = 1'b1;
        @(negedge clk);
        check("rerelease_ready", 32'(bus.ready), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
